// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared access-size encodings and FSM state type for the
//                byte-lane data memory.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_load_ext.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_load_ext
//  Description : Big-endian sub-word extraction with sign/zero extension.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_load_ext
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [1:0]  MemSize,
    input  logic        MemUnsigned,
    output logic [31:0] ext
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        w_half = 16'h0000;
        ext    = 32'h0000_0000;

        // Offset 0 is the most significant byte (big-endian).
        case (off)
            2'd0:    w_byte = word[31:24];
            2'd1:    w_byte = word[23:16];
            2'd2:    w_byte = word[15:8];
            default: w_byte = word[7:0];
        endcase
        w_half = off[1] ? word[15:0] : word[31:16];

        case (MemSize)
            SZ_BYTE: ext = MemUnsigned ? {24'h000000, w_byte}
                                       : {{24{w_byte[7]}}, w_byte};
            SZ_HALF: ext = MemUnsigned ? {16'h0000, w_half}
                                       : {{16{w_half[15]}}, w_half};
            SZ_WORD: ext = word;
            default: ext = 32'h0000_0000;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_memory_bytelane.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_bytelane
//  Description : Word-organised data memory with byte-lane stores, extended
//                sub-word loads, fault detection and post-reset clearing.
//  Revision    : 1.0  initial release
// ============================================================================
module data_memory_bytelane
    import mem_pkg::*;
#(
    parameter int          DEPTH     = 128,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ERR_W     = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [31:0]      Address,
    input  logic [31:0]      Write_Data,
    input  logic             MemWrite,
    input  logic             MemRead,
    input  logic [1:0]       MemSize,
    input  logic             MemUnsigned,
    output logic [31:0]      Read_data,
    output logic             Ready,
    output logic             AddrErr,
    output logic [ERR_W-1:0] ErrCount
);

    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t             r_state;
    logic [c_IDX_W-1:0] r_clr_idx;
    logic               r_ready;
    logic [ERR_W-1:0]   r_err_cnt;
    logic [31:0]        r_mem [DEPTH];

    logic [31:0]        w_offs;
    logic [31:0]        w_word_idx;
    logic [c_IDX_W-1:0] w_idx;
    logic [1:0]         w_off;
    logic               w_size_err;
    logic               w_range_err;
    logic               w_access;
    logic               w_fault;
    logic               w_we;
    logic [3:0]         w_lane_en;
    logic [31:0]        w_wr_data;
    logic [31:0]        w_rd_word;
    logic [31:0]        w_ext;

    assign w_offs      = Address - BASE_ADDR;
    assign w_word_idx  = w_offs >> 2;
    assign w_idx       = w_word_idx[c_IDX_W-1:0];
    assign w_off       = Address[1:0];
    assign w_range_err = (Address < BASE_ADDR) || (w_word_idx >= 32'(DEPTH));

    always_comb begin
        w_size_err = 1'b0;
        case (MemSize)
            SZ_BYTE: w_size_err = 1'b0;
            SZ_HALF: w_size_err = w_off[0];
            SZ_WORD: w_size_err = (w_off != 2'b00);
            default: w_size_err = 1'b1;
        endcase
    end

    // Ready doubles as the "in IDLE" qualifier for every access.
    assign w_access = (MemRead | MemWrite) & r_ready;
    assign w_fault  = w_access & (w_size_err | w_range_err);
    assign w_we     = MemWrite & r_ready & ~w_fault;

    // Lane 3 holds bits [31:24]; data is replicated so lanes pick it directly.
    always_comb begin
        w_lane_en = 4'b0000;
        w_wr_data = Write_Data;
        case (MemSize)
            SZ_BYTE: begin
                w_lane_en = 4'b1000 >> w_off;
                w_wr_data = {4{Write_Data[7:0]}};
            end
            SZ_HALF: begin
                w_lane_en = w_off[1] ? 4'b0011 : 4'b1100;
                w_wr_data = {2{Write_Data[15:0]}};
            end
            SZ_WORD: w_lane_en = 4'b1111;
            default: w_lane_en = 4'b0000;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= ST_INIT;
            r_clr_idx <= '0;
            r_ready   <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_clr_idx <= r_clr_idx + c_IDX_W'(1);
                    if (r_clr_idx == c_IDX_W'(DEPTH - 1)) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    if (w_fault && (r_err_cnt != {ERR_W{1'b1}})) begin
                        r_err_cnt <= r_err_cnt + ERR_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (r_state == ST_INIT) begin
                r_mem[r_clr_idx] <= 32'h0000_0000;
            end else if (w_we) begin
                for (int l = 0; l < 4; l++) begin
                    if (w_lane_en[l]) begin
                        r_mem[w_idx][l*8 +: 8] <= w_wr_data[l*8 +: 8];
                    end
                end
            end
        end
    end

    assign w_rd_word = r_mem[w_idx];

    dmem_load_ext u_load_ext (
        .word        (w_rd_word),
        .off         (w_off),
        .MemSize     (MemSize),
        .MemUnsigned (MemUnsigned),
        .ext         (w_ext)
    );

    assign Read_data = (MemRead && r_ready && !w_fault) ? w_ext : 32'h0000_0000;
    assign Ready     = r_ready;
    assign AddrErr   = w_fault;
    assign ErrCount  = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_bytelane.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_memory_bytelane
//  Description : Directed self-checking bench for data_memory_bytelane.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_data_memory_bytelane;

    localparam int c_DEPTH = 128;

    logic        CLK;
    logic        RESET;
    logic [31:0] Address;
    logic [31:0] Write_Data;
    logic        MemWrite;
    logic        MemRead;
    logic [1:0]  MemSize;
    logic        MemUnsigned;
    logic [31:0] Read_data;
    logic        Ready;
    logic        AddrErr;
    logic [15:0] ErrCount;

    int n_tests = 0;
    int n_fail  = 0;

    data_memory_bytelane #(
        .DEPTH     (c_DEPTH),
        .BASE_ADDR (32'h0000_0000),
        .ERR_W     (16)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .Address     (Address),
        .Write_Data  (Write_Data),
        .MemWrite    (MemWrite),
        .MemRead     (MemRead),
        .MemSize     (MemSize),
        .MemUnsigned (MemUnsigned),
        .Read_data   (Read_data),
        .Ready       (Ready),
        .AddrErr     (AddrErr),
        .ErrCount    (ErrCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                         input logic exp_err, input string tag);
        Address = a; Write_Data = d; MemSize = sz; MemWrite = 1'b1; MemRead = 1'b0;
        #1;
        chk(tag, {31'b0, AddrErr}, {31'b0, exp_err});
        tick();
        MemWrite = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic u,
                        input logic [31:0] exp, input logic exp_err, input string tag);
        Address = a; MemSize = sz; MemUnsigned = u; MemRead = 1'b1; MemWrite = 1'b0;
        #1;
        chk(tag, Read_data, exp);
        chk({tag, "_err"}, {31'b0, AddrErr}, {31'b0, exp_err});
        tick();
        MemRead = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; Address = 32'h0; Write_Data = 32'h0;
        MemWrite = 1'b0; MemRead = 1'b1; MemSize = 2'b10; MemUnsigned = 1'b0;
        tick();
        tick();
        chk("rst_ready",    {31'b0, Ready},   32'h0);
        chk("rst_errcnt",   {16'b0, ErrCount}, 32'h0);
        chk("rst_addrerr",  {31'b0, AddrErr}, 32'h0);
        chk("rst_readdata", Read_data,        32'h0);

        // Release reset; poke a store and a bad address while clearing.
        RESET = 1'b0;
        MemWrite = 1'b1; Address = 32'h40; Write_Data = 32'hDEAD_BEEF;
        for (int i = 1; i <= c_DEPTH; i++) begin
            if (i == 10) Address = 32'h200;
            if (i == 20) Address = 32'h40;
            if (i == c_DEPTH) begin
                MemWrite = 1'b0; MemRead = 1'b0;
            end
            tick();
            chk($sformatf("init_ready_%0d", i), {31'b0, Ready}, {31'b0, (i == c_DEPTH)});
            if (i == 10) begin
                chk("init_addrerr_gated", {31'b0, AddrErr}, 32'h0);
                chk("init_read_gated",    Read_data,        32'h0);
            end
        end
        chk("init_errcnt", {16'b0, ErrCount}, 32'h0);

        load(32'h00, 2'b10, 1'b0, 32'h0, 1'b0, "lw_0_cleared");
        load(32'h40, 2'b10, 1'b0, 32'h0, 1'b0, "lw_40_init_write_ignored");

        store(32'h10, 32'h1122_3344, 2'b10, 1'b0, "sw_10");
        load(32'h11, 2'b00, 1'b0, 32'h0000_0022, 1'b0, "lb_11");
        load(32'h13, 2'b00, 1'b1, 32'h0000_0044, 1'b0, "lbu_13");
        load(32'h12, 2'b01, 1'b0, 32'h0000_3344, 1'b0, "lh_12");

        store(32'h20, 32'h80FF_7F01, 2'b10, 1'b0, "sw_20");
        load(32'h20, 2'b00, 1'b0, 32'hFFFF_FF80, 1'b0, "lb_20");
        load(32'h20, 2'b00, 1'b1, 32'h0000_0080, 1'b0, "lbu_20");
        load(32'h20, 2'b01, 1'b0, 32'hFFFF_80FF, 1'b0, "lh_20");
        load(32'h20, 2'b01, 1'b1, 32'h0000_80FF, 1'b0, "lhu_20");
        load(32'h22, 2'b01, 1'b0, 32'h0000_7F01, 1'b0, "lh_22");

        store(32'h20, 32'h0000_0000, 2'b10, 1'b0, "sw_20_zero");
        store(32'h22, 32'h0000_00AB, 2'b00, 1'b0, "sb_22");
        load(32'h20, 2'b10, 1'b0, 32'h0000_AB00, 1'b0, "lw_after_sb");
        store(32'h20, 32'h0000_BEEF, 2'b01, 1'b0, "sh_20");
        load(32'h20, 2'b10, 1'b0, 32'hBEEF_AB00, 1'b0, "lw_after_sh");

        // Faulted accesses.
        store(32'h06, 32'hFFFF_FFFF, 2'b10, 1'b1, "sw_06_misaligned");
        load(32'h04, 2'b10, 1'b0, 32'h0, 1'b0, "lw_04_unchanged");
        load(32'h03, 2'b01, 1'b0, 32'h0, 1'b1, "lh_03_misaligned");
        load(32'h200, 2'b10, 1'b0, 32'h0, 1'b1, "lw_200_range");
        chk("errcnt_3", {16'b0, ErrCount}, 32'd3);
        load(32'h10, 2'b11, 1'b0, 32'h0, 1'b1, "reserved_size");
        chk("errcnt_4", {16'b0, ErrCount}, 32'd4);
        load(32'h10, 2'b10, 1'b0, 32'h1122_3344, 1'b0, "lw_10_unchanged");

        // Read and write together: old data visible, new data after the edge.
        Address = 32'h10; MemSize = 2'b10; Write_Data = 32'hCAFE_F00D;
        MemRead = 1'b1; MemWrite = 1'b1;
        #1;
        chk("rw_same_old", Read_data, 32'h1122_3344);
        tick();
        MemWrite = 1'b0; MemRead = 1'b0;
        #1;
        chk("read_disabled", Read_data, 32'h0);
        load(32'h10, 2'b10, 1'b0, 32'hCAFE_F00D, 1'b0, "rw_same_new");

        // Fault and RESET at the same edge: reset wins.
        Address = 32'h200; MemRead = 1'b1; RESET = 1'b1;
        #1;
        chk("fault_before_reset", {31'b0, AddrErr}, 32'h1);
        tick();
        MemRead = 1'b0;
        chk("errcnt_reset_wins", {16'b0, ErrCount}, 32'h0);
        chk("ready_after_reset", {31'b0, Ready},   32'h0);

        // Reset pulse part-way through the clear restarts it.
        RESET = 1'b0;
        for (int i = 0; i < 50; i++) tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        for (int i = 1; i <= c_DEPTH; i++) begin
            tick();
            if (i >= c_DEPTH - 1) begin
                chk($sformatf("restart_ready_%0d", i), {31'b0, Ready}, {31'b0, (i == c_DEPTH)});
            end
        end
        chk("restart_errcnt", {16'b0, ErrCount}, 32'h0);
        load(32'h10, 2'b10, 1'b0, 32'h0, 1'b0, "lw_10_recleared");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
